// File: rtl/ex_operand_stage.sv
// ex_operand_stage: decode-to-execute pipeline register in front of the ALU.
//
// Captures one decoded instruction per valid/ready handshake. Register operands are
// resolved against the MEM and WB forward sources at capture time. Operand B selects
// the immediate or the forwarded rs2. Captured values are frozen until the entry
// leaves, so nothing is re-forwarded while stalled.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake (in_ready = !out_valid || out_ready)
//   in_rs1/in_rs2/in_rd    register indices
//   in_rs1_data/in_rs2_data register-file read data
//   in_imm, in_use_imm     immediate and operand-B select
//   in_aluop, in_reg_write ALU op code and write-enable for in_rd
//   mem_*, wb_*            forward sources (MEM has priority over WB)
//   flush                  drop the held entry and any capture this cycle
//   out_valid/out_ready    downstream handshake
//   a, b, aluop            registered ALU inputs
//   rd, reg_write          registered destination info
//   store_data             forwarded rs2, independent of in_use_imm
//   stall_count            saturating count of out_valid && !out_ready cycles
module ex_operand_stage #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [W-1:0]     in_rs1_data,
  input  logic [W-1:0]     in_rs2_data,
  input  logic [W-1:0]     in_imm,
  input  logic             in_use_imm,
  input  logic [3:0]       in_aluop,
  input  logic             in_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [W-1:0]     mem_result,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic [W-1:0]     wb_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [3:0]       aluop,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic [W-1:0]     store_data,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic             capture;
  logic [W-1:0]     rs1_fwd, rs2_fwd, b_sel;
  logic [W-1:0]     a_q, b_q, store_q;
  logic [3:0]       aluop_q;
  logic [4:0]       rd_q;
  logic             reg_write_q;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Ready does not look at in_valid, so upstream can use it without a comb loop.
  assign in_ready = (state_q == StEmpty) || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // x0 never forwards; MEM is younger than WB so it wins a double match.
  always_comb begin
    rs1_fwd = in_rs1_data;
    if (in_rs1 == 5'd0) begin
      rs1_fwd = '0;
    end else if (mem_reg_write && (mem_rd == in_rs1)) begin
      rs1_fwd = mem_result;
    end else if (wb_reg_write && (wb_rd == in_rs1)) begin
      rs1_fwd = wb_result;
    end
  end

  always_comb begin
    rs2_fwd = in_rs2_data;
    if (in_rs2 == 5'd0) begin
      rs2_fwd = '0;
    end else if (mem_reg_write && (mem_rd == in_rs2)) begin
      rs2_fwd = mem_result;
    end else if (wb_reg_write && (wb_rd == in_rs2)) begin
      rs2_fwd = wb_result;
    end
  end

  assign b_sel = in_use_imm ? in_imm : rs2_fwd;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (capture) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (flush) begin
          state_d = StEmpty;
        end else if (capture) begin
          state_d = StFull;
        end else if (out_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StFull) && !out_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      a_q         <= '0;
      b_q         <= '0;
      store_q     <= '0;
      aluop_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      // Flush only drops the valid bit; the payload keeps its last value.
      if (capture) begin
        a_q         <= rs1_fwd;
        b_q         <= b_sel;
        store_q     <= rs2_fwd;
        aluop_q     <= in_aluop;
        rd_q        <= in_rd;
        reg_write_q <= in_reg_write;
      end
    end
  end

  assign out_valid   = (state_q == StFull);
  assign a           = a_q;
  assign b           = b_q;
  assign store_data  = store_q;
  assign aluop       = aluop_q;
  assign rd          = rd_q;
  assign reg_write   = reg_write_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected payloads are queued at capture and
// compared every cycle the entry is held, then retired on consume or flush.
module tb_ex_operand_stage;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rs1, in_rs2, in_rd;
  logic [W-1:0]     in_rs1_data, in_rs2_data, in_imm;
  logic             in_use_imm;
  logic [3:0]       in_aluop;
  logic             in_reg_write;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic [W-1:0]     mem_result;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic [W-1:0]     wb_result;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     a, b, store_data;
  logic [3:0]       aluop;
  logic [4:0]       rd;
  logic             reg_write;
  logic [CNT_W-1:0] stall_count;

  ex_operand_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_use_imm   (in_use_imm),
    .in_aluop     (in_aluop),
    .in_reg_write (in_reg_write),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .mem_result   (mem_result),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_result    (wb_result),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .a            (a),
    .b            (b),
    .aluop        (aluop),
    .rd           (rd),
    .reg_write    (reg_write),
    .store_data   (store_data),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sd;
    logic [3:0]   op;
    logic [4:0]   rd;
    logic         rw;
  } exp_t;

  exp_t             sb[$];
  logic             m_valid;
  logic [CNT_W-1:0] m_cnt;
  int               total;
  int               bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fwd_ref(input logic [4:0] s, input logic [W-1:0] rf);
    if (s == 5'd0) return '0;
    if (mem_reg_write && mem_rd == s) return mem_result;
    if (wb_reg_write && wb_rd == s) return wb_result;
    return rf;
  endfunction

  // One clock: check held state at negedge, advance the model, return #1 after posedge.
  task automatic cycle();
    logic cap;
    exp_t e;
    @(negedge clk);
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    check_eq("stall_count", 64'(stall_count), 64'(m_cnt));
    if (m_valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_empty", 64'd1, 64'd0);
      end else begin
        check_eq("a", 64'(a), 64'(sb[0].a));
        check_eq("b", 64'(b), 64'(sb[0].b));
        check_eq("store_data", 64'(store_data), 64'(sb[0].sd));
        check_eq("aluop", 64'(aluop), 64'(sb[0].op));
        check_eq("rd", 64'(rd), 64'(sb[0].rd));
        check_eq("reg_write", {63'd0, reg_write}, {63'd0, sb[0].rw});
      end
    end
    cap = in_valid && (!m_valid || out_ready) && !flush && !reset;
    if (reset) begin
      sb.delete();
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      if (m_valid && !out_ready && !flush && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
      if (m_valid && (flush || out_ready) && sb.size() > 0) void'(sb.pop_front());
      if (cap) begin
        e.a  = fwd_ref(in_rs1, in_rs1_data);
        e.sd = fwd_ref(in_rs2, in_rs2_data);
        e.b  = in_use_imm ? in_imm : e.sd;
        e.op = in_aluop;
        e.rd = in_rd;
        e.rw = in_reg_write;
        sb.push_back(e);
      end
      if (flush) m_valid = 1'b0;
      else if (cap) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_insn();
    in_valid     = 1'b1;
    in_rs1       = 5'($urandom_range(0, 3));
    in_rs2       = 5'($urandom_range(0, 3));
    in_rd        = 5'($urandom);
    in_rs1_data  = $urandom;
    in_rs2_data  = $urandom;
    in_imm       = $urandom;
    in_use_imm   = 1'($urandom);
    in_aluop     = 4'($urandom);
    in_reg_write = 1'($urandom);
    mem_rd       = 5'($urandom_range(0, 3));
    mem_reg_write = 1'($urandom);
    mem_result   = $urandom;
    wb_rd        = 5'($urandom_range(0, 3));
    wb_reg_write = 1'($urandom);
    wb_result    = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_a"}, 64'(a), 64'd0);
    check_eq({tag, "_b"}, 64'(b), 64'd0);
    check_eq({tag, "_sd"}, 64'(store_data), 64'd0);
    check_eq({tag, "_op"}, 64'(aluop), 64'd0);
    check_eq({tag, "_rd"}, 64'(rd), 64'd0);
    check_eq({tag, "_rw"}, {63'd0, reg_write}, 64'd0);
    check_eq({tag, "_cnt"}, 64'(stall_count), 64'd0);
    check_eq({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_valid = 1'b0;
    m_cnt   = '0;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_use_imm = 1'b0; in_aluop = '0; in_reg_write = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    check_reset_values("rst");

    // Back-to-back stream with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      rand_insn();
      cycle();
      check_eq("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    cycle();

    // MEM beats WB on a double match, WB used when MEM is not writing.
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs1_data = 32'h11; in_rs2 = 5'd7; in_rs2_data = 32'h44;
    in_use_imm = 1'b0; mem_rd = 5'd5; mem_result = 32'h22; mem_reg_write = 1'b1;
    wb_rd = 5'd5; wb_result = 32'h33; wb_reg_write = 1'b1;
    cycle();
    check_eq("fwd_mem_a", 64'(a), 64'h22);
    check_eq("no_fwd_b", 64'(b), 64'h44);
    mem_reg_write = 1'b0;
    cycle();
    check_eq("fwd_wb_a", 64'(a), 64'h33);

    // x0 is never forwarded; immediate selects only operand B.
    in_rs2 = 5'd0; in_rs2_data = 32'h55; wb_rd = 5'd0; wb_result = 32'hFFFF_FFFF;
    mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h66;
    cycle();
    check_eq("x0_b", 64'(b), 64'd0);
    check_eq("x0_sd", 64'(store_data), 64'd0);
    in_use_imm = 1'b1; in_imm = 32'hFFFF_FFF0;
    cycle();
    check_eq("imm_b", 64'(b), 64'hFFFF_FFF0);
    check_eq("imm_sd", 64'(store_data), 64'd0);
    in_valid = 1'b0;
    cycle();

    // Stall three cycles while forward sources change underneath.
    rand_insn();
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_insn();
      cycle();
    end
    check_eq("stall3_cnt", 64'(stall_count), 64'd3);
    check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    rand_insn();
    cycle();
    check_eq("b2b_valid", {63'd0, out_valid}, 64'd1);

    // Flush while full and capturing: nothing taken, next one accepted.
    rand_insn();
    flush = 1'b1;
    cycle();
    check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;
    rand_insn();
    cycle();
    check_eq("post_flush_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    cycle();

    // Saturate the stall counter, then reset in the middle of the stall.
    rand_insn();
    cycle();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 65540; i++) cycle();
    check_eq("sat_cnt", 64'(stall_count), 64'hFFFF);
    rand_insn();
    reset = 1'b1;
    cycle();
    check_reset_values("mid_rst");
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
